// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forwarding codes, HI/LO select codes and divide-FSM state type
package hazard_pkg;

  // Forwarding mux selects for the E-stage operand muxes
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  // HI/LO read-source selects for forwardhiloE
  localparam logic [2:0] HILO_NONE  = 3'b000;
  localparam logic [2:0] HILO_HI_RF = 3'b001;
  localparam logic [2:0] HILO_LO_RF = 3'b010;
  localparam logic [2:0] HILO_HI_M  = 3'b011;
  localparam logic [2:0] HILO_LO_M  = 3'b100;
  localparam logic [2:0] HILO_HI_W  = 3'b101;
  localparam logic [2:0] HILO_LO_W  = 3'b110;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_stall_fsm.sv
// rtl/div_stall_fsm.sv - multi-cycle divide stall sequencer (IDLE/BUSY/DONE)
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_startE,
  input  logic excM,
  input  logic memstall,
  output logic divstall,
  output logic div_doneE
);

  // Issue cycle stalls from IDLE, then BUSY covers the remaining DIV_CYCLES-1 cycles
  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DIV_CYCLES - 2);

  div_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  // State and countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and stall generation; an exception aborts any divide in flight
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    divstall  = 1'b0;
    div_doneE = (state == DIV_DONE);
    case (state)
      DIV_IDLE: begin
        if (div_startE) begin
          divstall = 1'b1;
          state_n  = DIV_BUSY;
          cnt_n    = LOAD;
        end
      end
      DIV_BUSY: begin
        divstall = 1'b1;
        if (cnt == '0) state_n = DIV_DONE;
        else           cnt_n   = cnt - 1'b1;
      end
      DIV_DONE: begin
        if (!memstall) state_n = DIV_IDLE;
      end
      default: begin
        state_n = DIV_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (excM) begin
      state_n  = DIV_IDLE;
      cnt_n    = '0;
      divstall = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard unit; HAZARD_PERF_EN enables stall perf counters
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              branchD,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              regwriteW,
  input  logic              mfhiE,
  input  logic              mfloE,
  input  logic              hi_writeM,
  input  logic              lo_writeM,
  input  logic              hi_writeW,
  input  logic              lo_writeW,
  input  logic              div_startE,
  input  logic              excM,
  input  logic              mem_reqM,
  input  logic              mem_readyM,
  input  logic              perf_clr,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic [2:0]        forwardhiloE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_busy,
  output logic              div_doneE,
  output logic [PERF_W-1:0] cnt_lw,
  output logic [PERF_W-1:0] cnt_br,
  output logic [PERF_W-1:0] cnt_div,
  output logic [PERF_W-1:0] cnt_mem
);

  logic lwstall, brstall, memstall, divstall, any_stall;

  // Decode-stage branch comparator forwarding from M
  assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

  // Execute-stage operand forwarding; the younger M result wins over W
  always_comb begin
    forwardaE = FWD_NONE;
    forwardbE = FWD_NONE;
    if (rsE != '0 && rsE == writeregM && regwriteM)      forwardaE = FWD_M;
    else if (rsE != '0 && rsE == writeregW && regwriteW) forwardaE = FWD_W;
    if (rtE != '0 && rtE == writeregM && regwriteM)      forwardbE = FWD_M;
    else if (rtE != '0 && rtE == writeregW && regwriteW) forwardbE = FWD_W;
  end

  // HI/LO read source for mfhi/mflo in E
  always_comb begin
    forwardhiloE = HILO_NONE;
    if (mfhiE)      forwardhiloE = hi_writeM ? HILO_HI_M : (hi_writeW ? HILO_HI_W : HILO_HI_RF);
    else if (mfloE) forwardhiloE = lo_writeM ? HILO_LO_M : (lo_writeW ? HILO_LO_W : HILO_LO_RF);
  end

  assign lwstall  = memtoregE && (rtE != '0) && (rtE == rsD || rtE == rtD);
  assign brstall  = branchD &&
                    ((regwriteE && writeregE != '0 && (writeregE == rsD || writeregE == rtD)) ||
                     (memtoregM && writeregM != '0 && (writeregM == rsD || writeregM == rtD)));
  assign memstall = mem_reqM && !mem_readyM;

  div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk        (clk),
    .rst        (rst),
    .div_startE (div_startE),
    .excM       (excM),
    .memstall   (memstall),
    .divstall   (divstall),
    .div_doneE  (div_doneE)
  );

  // An exception overrides every stall so the flush can take effect
  assign any_stall = lwstall | brstall | divstall | memstall;
  assign stallM    = !excM && memstall;
  assign stallE    = !excM && (divstall || memstall);
  assign stallD    = !excM && any_stall;
  assign stallF    = stallD;
  assign div_busy  = divstall;

  // Bubble into E only when E itself is free to advance
  assign flushD = excM;
  assign flushE = excM || ((lwstall || brstall) && !(divstall || memstall));
  assign flushM = excM;
  assign flushW = excM;

`ifdef HAZARD_PERF_EN
  logic [3:0]        perf_inc;
  logic [PERF_W-1:0] perf_q [4];

  assign perf_inc = {lwstall, brstall, divstall, memstall};

  // Saturating stall-cycle counters; clear takes priority over increment
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || perf_clr)                        perf_q[i] <= '0;
      else if (perf_inc[i] && (perf_q[i] != '1)) perf_q[i] <= perf_q[i] + PERF_W'(1);
    end
  end

  assign cnt_lw  = perf_q[3];
  assign cnt_br  = perf_q[2];
  assign cnt_div = perf_q[1];
  assign cnt_mem = perf_q[0];
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign cnt_lw  = '0;
  assign cnt_br  = '0;
  assign cnt_div = '0;
  assign cnt_mem = '0;
`endif

endmodule
